// File: rtl/pad_io_cond.sv
// pad_io_cond: conditioning stage between the pad ring and the core.
// - Pad inputs: SYNC_STAGES-deep synchroniser, then a per-channel glitch
//   filter that needs FILTER_LEN consecutive agreeing samples
//   (FILTER_LEN == 0 bypasses the filter).
// - Pad outputs: registered once, with reset value OUT_RST_VAL.
// - rst_core: asserts asynchronously with rst and deasserts synchronously.
// Optional macro PAD_IN_EDGE_EN adds the in_rise/in_fall edge pulse outputs.
module pad_io_cond #(
    parameter int unsigned      N_IN        = 5,
    parameter int unsigned      N_OUT       = 15,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter int unsigned      FILTER_LEN  = 4,
    parameter logic [N_IN-1:0]  IN_RST_VAL  = '0,
    parameter logic [N_OUT-1:0] OUT_RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IN-1:0]  pad_in,
    output logic [N_IN-1:0]  core_in,
    input  logic [N_OUT-1:0] core_out,
    output logic [N_OUT-1:0] pad_out,
    output logic             rst_core
`ifdef PAD_IN_EDGE_EN
    ,
    output logic [N_IN-1:0]  in_rise,
    output logic [N_IN-1:0]  in_fall
`endif
);

    // Elaboration-time parameter checks
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("pad_io_cond: SYNC_STAGES must be in 2..4");
    end
    if (N_IN < 1) begin : g_bad_n_in
        $error("pad_io_cond: N_IN must be >= 1");
    end
    if (N_OUT < 1) begin : g_bad_n_out
        $error("pad_io_cond: N_OUT must be >= 1");
    end

    // ------------------------------------------------------------------
    // Input synchroniser chain
    // ------------------------------------------------------------------
    logic [N_IN-1:0] sync_q [SYNC_STAGES];
    logic [N_IN-1:0] sync_last;

    assign sync_last = sync_q[SYNC_STAGES-1];

    // Shift raw pad values through the synchroniser stages
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= IN_RST_VAL;
            end
        end else begin
            sync_q[0] <= pad_in;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Glitch filter
    // ------------------------------------------------------------------
    if (FILTER_LEN > 0) begin : g_filter
        localparam int unsigned     CW       = $clog2(FILTER_LEN + 1);
        localparam logic [CW-1:0]   CNT_LAST = CW'(FILTER_LEN - 1);

        logic [CW-1:0]   cnt_q [N_IN];
        logic [CW-1:0]   cnt_d [N_IN];
        logic [N_IN-1:0] core_q;
        logic [N_IN-1:0] core_d;

        // Per channel: count consecutive disagreeing samples; adopt the new
        // level on the FILTER_LEN-th one, drop the count on any agreement
        always_comb begin
            core_d = core_q;
            for (int unsigned i = 0; i < N_IN; i++) begin
                cnt_d[i] = '0;
                if (sync_last[i] == core_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    core_d[i] = sync_last[i];
                    cnt_d[i]  = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end

        // Filter state registers
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                core_q <= IN_RST_VAL;
                for (int unsigned i = 0; i < N_IN; i++) begin
                    cnt_q[i] <= '0;
                end
            end else begin
                core_q <= core_d;
                for (int unsigned i = 0; i < N_IN; i++) begin
                    cnt_q[i] <= cnt_d[i];
                end
            end
        end

        assign core_in = core_q;
    end else begin : g_no_filter
        assign core_in = sync_last;
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic [N_OUT-1:0] pad_out_q;

    // Register core outputs once before the pads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pad_out_q <= OUT_RST_VAL;
        end else begin
            pad_out_q <= core_out;
        end
    end

    assign pad_out = pad_out_q;

    // ------------------------------------------------------------------
    // Core reset synchroniser
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] rst_sync_q;

    // Async set on rst, shift zeros in so release happens on the
    // SYNC_STAGES-th edge after rst falls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_sync_q <= '1;
        end else begin
            rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign rst_core = rst_sync_q[SYNC_STAGES-1];

`ifdef PAD_IN_EDGE_EN
    // ------------------------------------------------------------------
    // Edge detection on the conditioned inputs
    // ------------------------------------------------------------------
    logic [N_IN-1:0] prev_q;

    // Previous-cycle copy of core_in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= IN_RST_VAL;
        end else begin
            prev_q <= core_in;
        end
    end

    assign in_rise = core_in & ~prev_q;
    assign in_fall = ~core_in & prev_q;
`endif

endmodule

// File: tb/tb_pad_io_cond.sv
// Self-checking bench for pad_io_cond.
// DUT A: SYNC_STAGES=2, FILTER_LEN=4, OUT_RST_VAL=15'h7FFF.
// DUT B: SYNC_STAGES=3, FILTER_LEN=0 (filter bypassed).
// Edge-pulse checks are compiled in when PAD_IN_EDGE_EN is defined.
module tb_pad_io_cond;

    logic        clk;
    logic        rst;
    logic [4:0]  pad_a;
    logic [4:0]  pad_b;
    logic [14:0] core_out;
    logic [4:0]  core_in_a;
    logic [4:0]  core_in_b;
    logic [14:0] pad_out_a;
    logic [14:0] pad_out_b;
    logic        rst_core_a;
    logic        rst_core_b;
`ifdef PAD_IN_EDGE_EN
    logic [4:0]  in_rise_a;
    logic [4:0]  in_fall_a;
    logic [4:0]  in_rise_b;
    logic [4:0]  in_fall_b;
`endif

    int checks   = 0;
    int failures = 0;

    pad_io_cond #(
        .N_IN        (5),
        .N_OUT       (15),
        .SYNC_STAGES (2),
        .FILTER_LEN  (4),
        .IN_RST_VAL  (5'h00),
        .OUT_RST_VAL (15'h7FFF)
    ) dut_a (
        .clk      (clk),
        .rst      (rst),
        .pad_in   (pad_a),
        .core_in  (core_in_a),
        .core_out (core_out),
        .pad_out  (pad_out_a),
        .rst_core (rst_core_a)
`ifdef PAD_IN_EDGE_EN
        ,
        .in_rise  (in_rise_a),
        .in_fall  (in_fall_a)
`endif
    );

    pad_io_cond #(
        .N_IN        (5),
        .N_OUT       (15),
        .SYNC_STAGES (3),
        .FILTER_LEN  (0),
        .IN_RST_VAL  (5'h00),
        .OUT_RST_VAL (15'h0000)
    ) dut_b (
        .clk      (clk),
        .rst      (rst),
        .pad_in   (pad_b),
        .core_in  (core_in_b),
        .core_out (core_out),
        .pad_out  (pad_out_b),
        .rst_core (rst_core_b)
`ifdef PAD_IN_EDGE_EN
        ,
        .in_rise  (in_rise_b),
        .in_fall  (in_fall_b)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (got timeout, need $finish)");
        $fatal(1);
    end

    typedef struct {
        logic [4:0] pad_a;
        logic [4:0] exp_a;
        logic [4:0] pad_b;
        logic [4:0] exp_b;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [4:0] pa, input logic [4:0] ea,
                       input logic [4:0] pb, input logic [4:0] eb, input int n);
        for (int j = 0; j < n; j++) begin
            vecs.push_back('{pa, ea, pb, eb});
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one rising edge and land 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [14:0] cval;

        // ---- Vector table: one row per clock edge ----
        // Latency on bit0 (A: 6 edges) and bypass of 1F (B: 3 edges)
        add(5'h01, 5'h00, 5'h1F, 5'h00, 2);
        add(5'h01, 5'h00, 5'h1F, 5'h1F, 3);
        add(5'h01, 5'h01, 5'h1F, 5'h1F, 3);
        // 3-cycle glitch on bit1 of A is rejected; B falls to 0
        add(5'h03, 5'h01, 5'h00, 5'h1F, 2);
        add(5'h03, 5'h01, 5'h00, 5'h00, 1);
        add(5'h01, 5'h01, 5'h00, 5'h00, 3);
        // 4-cycle pulse on bit1 of A passes as a 4-cycle pulse, 6 edges late;
        // 1-cycle pulse on bit2 of B passes as a 1-cycle pulse, 3 edges late
        add(5'h03, 5'h01, 5'h04, 5'h00, 1);
        add(5'h03, 5'h01, 5'h00, 5'h00, 1);
        add(5'h03, 5'h01, 5'h00, 5'h04, 1);
        add(5'h03, 5'h01, 5'h00, 5'h00, 1);
        add(5'h01, 5'h01, 5'h00, 5'h00, 1);
        add(5'h01, 5'h03, 5'h00, 5'h00, 4);
        add(5'h01, 5'h01, 5'h00, 5'h00, 2);
        // All channels of A change together, up then down
        add(5'h1F, 5'h01, 5'h00, 5'h00, 5);
        add(5'h1F, 5'h1F, 5'h00, 5'h00, 2);
        add(5'h00, 5'h1F, 5'h00, 5'h00, 5);
        add(5'h00, 5'h00, 5'h00, 5'h00, 2);

        // ---- Reset state ----
        rst      = 1'b0;
        pad_a    = 5'h00;
        pad_b    = 5'h00;
        core_out = 15'h0000;
        #2 rst = 1'b1;
        #1;
        check("async_rst_core_a", rst_core_a, 1'b1);
        check("async_pad_out_a", pad_out_a, 15'h7FFF);
        repeat (3) tick();
        core_out = 15'h5555;
        tick();
        check("rst_core_in_a", core_in_a, 5'h00);
        check("rst_core_in_b", core_in_b, 5'h00);
        check("rst_pad_out_a", pad_out_a, 15'h7FFF);
        check("rst_pad_out_b", pad_out_b, 15'h0000);
        check("rst_rst_core_a", rst_core_a, 1'b1);
        check("rst_rst_core_b", rst_core_b, 1'b1);
`ifdef PAD_IN_EDGE_EN
        check("rst_in_rise_a", in_rise_a, 5'h00);
        check("rst_in_fall_a", in_fall_a, 5'h00);
`endif

        // ---- Release: rst_core A low on edge 2, B low on edge 3 ----
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("rel%0d_rst_core_a", k), rst_core_a, (k < 2) ? 1'b1 : 1'b0);
            check($sformatf("rel%0d_rst_core_b", k), rst_core_b, (k < 3) ? 1'b1 : 1'b0);
            if (k == 1) begin
                check("rel1_pad_out_a", pad_out_a, 15'h5555);
`ifdef PAD_IN_EDGE_EN
                check("rel1_in_rise_a", in_rise_a, 5'h00);
                check("rel1_in_fall_a", in_fall_a, 5'h00);
`endif
            end
        end

        // ---- Apply vector table ----
        for (int i = 0; i < vecs.size(); i++) begin
            pad_a    = vecs[i].pad_a;
            pad_b    = vecs[i].pad_b;
            cval     = 15'h1234 + 15'(i * 32'h0321);
            core_out = cval;
            tick();
            check($sformatf("tbl%0d_core_in_a", i), core_in_a, vecs[i].exp_a);
            check($sformatf("tbl%0d_core_in_b", i), core_in_b, vecs[i].exp_b);
            check($sformatf("tbl%0d_pad_out_a", i), pad_out_a, cval);
        end

        // ---- Reset mid-count: bit2 disagreeing with cnt=2 ----
        pad_a = 5'h01;
        repeat (8) tick();
        check("pre_mid_core_in_a", core_in_a, 5'h01);
        pad_a = 5'h05;
        repeat (4) tick();
        check("mid_count_core_in_a", core_in_a, 5'h01);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_core_in_a", core_in_a, 5'h00);
        check("mid_rst_rst_core_a", rst_core_a, 1'b1);
        check("mid_rst_pad_out_a", pad_out_a, 15'h7FFF);
        #1 rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("post%0d_rst_core_a", k), rst_core_a, (k < 2) ? 1'b1 : 1'b0);
            check($sformatf("post%0d_core_in_a", k), core_in_a, (k < 6) ? 5'h00 : 5'h05);
        end

        // ---- Reassert one edge into the release sequence ----
        rst = 1'b1;
        #1;
        check("re1_rst_core_a", rst_core_a, 1'b1);
        #3 rst = 1'b0;
        tick();
        check("re_edge1_rst_core_a", rst_core_a, 1'b1);
        rst = 1'b1;
        #1;
        check("re2_rst_core_a", rst_core_a, 1'b1);
        #3 rst = 1'b0;
        tick();
        check("restart_edge1_rst_core_a", rst_core_a, 1'b1);
        tick();
        check("restart_edge2_rst_core_a", rst_core_a, 1'b0);

        pad_a = 5'h00;
        repeat (10) tick();
        check("idle_core_in_a", core_in_a, 5'h00);

`ifdef PAD_IN_EDGE_EN
        // ---- Edge pulses on bit3: high 10 cycles then low 10 cycles ----
        for (int k = 0; k < 20; k++) begin
            pad_a = (k < 10) ? 5'h08 : 5'h00;
            tick();
            check($sformatf("edge%0d_core_in_a", k), core_in_a,
                  (k >= 5 && k < 15) ? 5'h08 : 5'h00);
            check($sformatf("edge%0d_in_rise_a", k), in_rise_a, (k == 5) ? 5'h08 : 5'h00);
            check($sformatf("edge%0d_in_fall_a", k), in_fall_a, (k == 15) ? 5'h08 : 5'h00);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
